// File: rtl/rect_buf_pkg.sv
// ============================================================================
// Module   : rect_buf_pkg
// Function : Shared types for the rectilinear row-buffer scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rect_buf_pkg;

  localparam int ROW_BITS = 16;

  typedef logic [ROW_BITS-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    RUN     = 2'd2,
    DRAIN   = 2'd3
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/rect_buf_occupancy.sv
// ============================================================================
// Module   : rect_buf_occupancy
// Function : Oldest-resident-row pointer, occupancy arithmetic, underflow flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rect_buf_occupancy
  import rect_buf_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_release,
  input  row_t i_wr_row,
  output row_t o_base_row,
  output row_t o_occ,
  output logic o_underflow
);

  row_t r_base_row;
  row_t w_occ;

  // Modular subtraction keeps occupancy correct across row-index wrap.
  assign w_occ       = i_wr_row - r_base_row;
  assign o_occ       = w_occ;
  assign o_base_row  = r_base_row;
  assign o_underflow = i_release && (w_occ == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base_row <= '0;
    end else if (i_clear) begin
      r_base_row <= '0;
    end else if (i_release && (w_occ != '0)) begin
      r_base_row <= r_base_row + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rect_buffer_scheduler.sv
// ============================================================================
// Module   : rect_buffer_scheduler
// Function : Frame FSM, writer back-pressure and reader grant arbitration.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rect_buffer_scheduler
  import rect_buf_pkg::*;
#(
  parameter  int BUFFER_H     = 32,
  parameter  int FRAME_H      = 1088,
  parameter  int PREFILL_ROWS = 8,
  localparam int AVAIL_W      = $clog2(BUFFER_H) + 1
) (
  input  logic               st_clk,
  input  logic               reset_n,
  input  logic               frame_start,
  input  row_t               wr_row,
  output logic               wr_ready,
  input  logic               rd_req,
  input  row_t               rd_req_row,
  output logic               rd_grant,
  input  logic               rd_release,
  output row_t               base_row,
  output logic [AVAIL_W-1:0] rows_avail,
  output logic               frame_done,
  output logic               err
);

  localparam row_t c_FRAME_ROW   = row_t'(FRAME_H);
  localparam row_t c_PREFILL_ROW = row_t'(PREFILL_ROWS);
  localparam row_t c_BUFFER_ROW  = row_t'(BUFFER_H);

  sched_state_t r_state;
  sched_state_t w_state_nxt;
  logic         r_grant;
  logic         r_frame_done;
  logic         r_err;
  row_t         r_wr_prev;

  row_t         w_occ;
  logic         w_underflow;
  logic         w_run_or_drain;
  logic         w_release_ok;
  logic         w_release_bad;
  logic         w_req_below;
  logic         w_wr_back;
  logic         w_grant_cond;
  logic         w_done_hit;
  logic         w_err_set;

  assign w_run_or_drain = (r_state == RUN) || (r_state == DRAIN);

  // frame_start overrides any coincident release or request, silently.
  assign w_release_ok  = rd_release && !frame_start && w_run_or_drain;
  assign w_release_bad = rd_release && !frame_start && !w_run_or_drain;
  assign w_req_below   = rd_req && !frame_start && (rd_req_row < base_row);
  assign w_wr_back     = !frame_start && (wr_row < r_wr_prev);
  assign w_grant_cond  = rd_req && !frame_start && w_run_or_drain && !r_grant &&
                         (rd_req_row >= base_row) && (rd_req_row < wr_row);
  assign w_done_hit    = !frame_start && (r_state == DRAIN) && (base_row == c_FRAME_ROW);
  assign w_err_set     = w_underflow | w_release_bad | w_req_below | w_wr_back;

  rect_buf_occupancy u_occupancy (
    .clk         (st_clk),
    .rst_n       (reset_n),
    .i_clear     (frame_start),
    .i_release   (w_release_ok),
    .i_wr_row    (wr_row),
    .o_base_row  (base_row),
    .o_occ       (w_occ),
    .o_underflow (w_underflow)
  );

  always_comb begin
    w_state_nxt = r_state;
    wr_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = IDLE;
      end
      PREFILL: begin
        wr_ready = (w_occ < c_BUFFER_ROW);
        if (wr_row >= c_PREFILL_ROW) w_state_nxt = RUN;
      end
      RUN: begin
        wr_ready = (w_occ < c_BUFFER_ROW);
        if (wr_row == c_FRAME_ROW) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (base_row == c_FRAME_ROW) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (frame_start) w_state_nxt = PREFILL;
  end

  always_ff @(posedge st_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      r_wr_prev    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_cond;
      r_frame_done <= w_done_hit;
      r_err        <= r_err | w_err_set;
      // The writer clears its count one cycle after frame_start.
      r_wr_prev    <= frame_start ? '0 : wr_row;
    end
  end

  assign rd_grant   = r_grant;
  assign frame_done = r_frame_done;
  assign err        = r_err;
  assign rows_avail = w_occ[AVAIL_W-1:0];

endmodule

`default_nettype wire
